// File: rtl/traffic_pkg.sv
// Shared phase codes, light encodings and config register map for the intersection scheduler.
package traffic_pkg;

    typedef enum logic [2:0] {
        PhMg  = 3'd0,
        PhMy  = 3'd1,
        PhAr1 = 3'd2,
        PhSg  = 3'd3,
        PhSy  = 3'd4,
        PhAr2 = 3'd5
    } phase_e;

    // Light vectors are {R,Y,G}.
    localparam logic [2:0] LightRed = 3'b100;
    localparam logic [2:0] LightYel = 3'b010;
    localparam logic [2:0] LightGrn = 3'b001;

    localparam logic [1:0] CfgMinGreen  = 2'd0;
    localparam logic [1:0] CfgYellow    = 2'd1;
    localparam logic [1:0] CfgSideGreen = 2'd2;
    localparam logic [1:0] CfgWalk      = 2'd3;

    function automatic logic [2:0] main_light(phase_e ph);
        case (ph)
            PhMg:    return LightGrn;
            PhMy:    return LightYel;
            default: return LightRed;
        endcase
    endfunction

    function automatic logic [2:0] side_light(phase_e ph);
        case (ph)
            PhSg:    return LightGrn;
            PhSy:    return LightYel;
            default: return LightRed;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Loadable down counter that steps on the external tick and reports when it has run out.
module traffic_phase_timer #(
    parameter int unsigned   TW     = 8,
    parameter logic [TW-1:0] RstVal = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          tick,
    output logic          zero
);

    logic [TW-1:0] count_q, count_d;

    // A load always beats a coincident tick.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RstVal;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven main/side phase scheduler: main rests in green, latched side/ped requests are
// served through yellow and all-red clearance, with durations taken from a small config file.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned TW         = 8,
    parameter int unsigned MIN_GREEN  = 20,
    parameter int unsigned YELLOW     = 6,
    parameter int unsigned SIDE_GREEN = 15,
    parameter int unsigned WALK       = 25,
    parameter int unsigned ALL_RED    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_addr,
    input  logic [TW-1:0] cfg_wdata,
    input  logic          side_req,
    input  logic          ped_req,
    output logic [2:0]    main_lights,
    output logic [2:0]    side_lights,
    output logic          walk,
    output logic [2:0]    phase,
    output logic          side_pending,
    output logic          ped_pending
);

    localparam logic [TW-1:0] MinGreenRst  = TW'(MIN_GREEN);
    localparam logic [TW-1:0] YellowRst    = TW'(YELLOW);
    localparam logic [TW-1:0] SideGreenRst = TW'(SIDE_GREEN);
    localparam logic [TW-1:0] WalkRst      = TW'(WALK);
    localparam logic [TW-1:0] AllRedVal    = TW'(ALL_RED);

    logic [TW-1:0] cfg_q [4];
    logic [TW-1:0] cfg_d [4];
    logic [TW-1:0] cfg_eff [4];

    phase_e     phase_q, phase_d;
    logic       side_pend_q, side_pend_d;
    logic       ped_pend_q, ped_pend_d;
    logic       serve_ped_q, serve_ped_d;
    logic [2:0] main_lt_q, main_lt_d;
    logic [2:0] side_lt_q, side_lt_d;
    logic       walk_q, walk_d;

    logic          tmr_load, tmr_zero;
    logic [TW-1:0] load_raw, load_val;

    // A write landing on the same edge as a load is visible to that load.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cfg_eff[i] = (cfg_we && (cfg_addr == 2'(i))) ? cfg_wdata : cfg_q[i];
        end
        cfg_d = cfg_eff;
    end

    always_comb begin
        phase_d     = phase_q;
        serve_ped_d = serve_ped_q;
        side_pend_d = side_pend_q | side_req;
        ped_pend_d  = ped_pend_q | ped_req;
        case (phase_q)
            PhMg:  if (tmr_zero && (side_pend_q || ped_pend_q)) phase_d = PhMy;
            PhMy:  if (tmr_zero) phase_d = PhAr1;
            PhAr1: begin
                if (tmr_zero) begin
                    phase_d     = PhSg;
                    serve_ped_d = ped_pend_q | ped_req;
                    side_pend_d = 1'b0;
                    ped_pend_d  = 1'b0;
                end
            end
            PhSg:  if (tmr_zero) phase_d = PhSy;
            PhSy:  if (tmr_zero) phase_d = PhAr2;
            PhAr2: if (tmr_zero) phase_d = PhMg;
            default: phase_d = PhMg;
        endcase

        tmr_load = (phase_d != phase_q);

        case (phase_d)
            PhMy, PhSy:   load_raw = cfg_eff[CfgYellow];
            PhAr1, PhAr2: load_raw = AllRedVal;
            PhSg: begin
                if (serve_ped_d && (cfg_eff[CfgWalk] > cfg_eff[CfgSideGreen])) begin
                    load_raw = cfg_eff[CfgWalk];
                end else begin
                    load_raw = cfg_eff[CfgSideGreen];
                end
            end
            default:      load_raw = cfg_eff[CfgMinGreen];
        endcase
        load_val = (load_raw == '0) ? TW'(1) : load_raw;

        main_lt_d = main_light(phase_d);
        side_lt_d = side_light(phase_d);
        walk_d    = (phase_d == PhSg) && serve_ped_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= PhMg;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
            serve_ped_q <= 1'b0;
            main_lt_q   <= LightGrn;
            side_lt_q   <= LightRed;
            walk_q      <= 1'b0;
            cfg_q[0]    <= MinGreenRst;
            cfg_q[1]    <= YellowRst;
            cfg_q[2]    <= SideGreenRst;
            cfg_q[3]    <= WalkRst;
        end else begin
            phase_q     <= phase_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
            serve_ped_q <= serve_ped_d;
            main_lt_q   <= main_lt_d;
            side_lt_q   <= side_lt_d;
            walk_q      <= walk_d;
            cfg_q       <= cfg_d;
        end
    end

    traffic_phase_timer #(
        .TW     (TW),
        .RstVal (MinGreenRst)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (load_val),
        .tick     (tick),
        .zero     (tmr_zero)
    );

    assign phase        = phase_q;
    assign main_lights  = main_lt_q;
    assign side_lights  = side_lt_q;
    assign walk         = walk_q;
    assign side_pending = side_pend_q;
    assign ped_pending  = ped_pend_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: a tick-level behavioural model is compared every
// cycle, and per-phase tick durations are pinned against hand-computed values.
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       side_req;
    logic       ped_req;
    logic [2:0] main_lights, side_lights, phase;
    logic       walk, side_pending, ped_pending;

    int total = 0;
    int bad   = 0;
    int div   = 0;
    logic walk_seen = 1'b0;

    always #5 clk = ~clk;

    traffic_phase_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .side_req     (side_req),
        .ped_req      (ped_req),
        .main_lights  (main_lights),
        .side_lights  (side_lights),
        .walk         (walk),
        .phase        (phase),
        .side_pending (side_pending),
        .ped_pending  (ped_pending)
    );

    // Model: phase index 0..5 in service order, ticks remaining before the phase may end.
    int   m_cfg [4];
    int   n_cfg [4];
    int   m_phase, n_phase, m_rem, n_rem;
    logic m_side, n_side, m_ped, n_ped, m_serve, n_serve;

    function automatic int phase_len(int p, logic sv, int mg, int yl, int sg, int wk);
        int v;
        case (p)
            0:       v = mg;
            1, 4:    v = yl;
            2, 5:    v = 2;
            default: v = (sv && wk > sg) ? wk : sg;
        endcase
        return (v == 0) ? 1 : v;
    endfunction

    function automatic logic [2:0] m_main_lt(int p);
        return (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
    endfunction

    function automatic logic [2:0] m_side_lt(int p);
        return (p == 3) ? 3'b001 : (p == 4) ? 3'b010 : 3'b100;
    endfunction

    always_comb begin
        n_cfg = m_cfg;
        if (cfg_we) n_cfg[cfg_addr] = int'(cfg_wdata);
        n_side  = m_side | side_req;
        n_ped   = m_ped | ped_req;
        n_serve = m_serve;
        n_phase = m_phase;
        n_rem   = m_rem;
        if (m_rem == 0 && (m_phase != 0 || m_side || m_ped)) begin
            n_phase = (m_phase + 1) % 6;
            if (m_phase == 2) begin
                n_serve = m_ped | ped_req;
                n_side  = 1'b0;
                n_ped   = 1'b0;
            end
            n_rem = phase_len(n_phase, n_serve, n_cfg[0], n_cfg[1], n_cfg[2], n_cfg[3]);
        end else if (tick && m_rem > 0) begin
            n_rem = m_rem - 1;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cfg   <= '{20, 6, 15, 25};
            m_phase <= 0;
            m_rem   <= 20;
            m_side  <= 1'b0;
            m_ped   <= 1'b0;
            m_serve <= 1'b0;
        end else begin
            m_cfg   <= n_cfg;
            m_phase <= n_phase;
            m_rem   <= n_rem;
            m_side  <= n_side;
            m_ped   <= n_ped;
            m_serve <= n_serve;
        end
    end

    // Ticks consumed per phase visit, indexed by phase code of the visit that just ended.
    int last_dur [6];
    int run_cnt;
    int prev_ph;

    always @(posedge clk) begin
        if (reset) begin
            run_cnt <= 0;
            prev_ph <= 0;
        end else if (int'(phase) != prev_ph) begin
            last_dur[prev_ph] <= run_cnt;
            run_cnt           <= tick ? 1 : 0;
            prev_ph           <= int'(phase);
        end else begin
            run_cnt <= run_cnt + (tick ? 1 : 0);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: compare at the falling edge, then advance the tick divider.
    task automatic cyc();
        logic [11:0] got, exp;
        @(negedge clk);
        if (!reset) begin
            got = {phase, main_lights, side_lights, walk, side_pending, ped_pending};
            exp = {3'(m_phase), m_main_lt(m_phase), m_side_lt(m_phase),
                   (m_phase == 3) && m_serve, m_side, m_ped};
            chk("model_cycle", int'(got), int'(exp));
            if (walk) walk_seen = 1'b1;
        end
        tick = !reset && (div == 3);
        div  = reset ? 0 : (div + 1) % 4;
    endtask

    task automatic run_ticks(input int n);
        int got_t = 0;
        while (got_t < n) begin
            cyc();
            if (tick) got_t++;
        end
    endtask

    task automatic wait_phase(input int ph, input int budget);
        logic hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            cyc();
            if (int'(phase) == ph) hit = 1'b1;
        end
        chk($sformatf("reach_phase_%0d", ph), int'(hit), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic pulse_side();
        side_req = 1'b1;
        cyc();
        side_req = 1'b0;
    endtask

    task automatic full_side_cycle(input string nm, input int sg_exp);
        pulse_side();
        wait_phase(3, 400);
        wait_phase(0, 400);
        cyc();
        cyc();
        chk(nm, last_dur[3], sg_exp);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'd0;
        side_req = 1'b0; ped_req = 1'b0;
        do_reset();
        chk("rst_phase", int'(phase), 0);
        chk("rst_main", int'(main_lights), 1);
        chk("rst_side", int'(side_lights), 4);
        chk("rst_walk_pend", int'({walk, side_pending, ped_pending}), 0);

        // Idle: rests in main green
        run_ticks(200);
        chk("idle_phase", int'(phase), 0);
        chk("idle_main", int'(main_lights), 1);
        chk("idle_walk_seen", int'(walk_seen), 0);

        // Side request at tick 5: nominal durations, no walk
        do_reset();
        walk_seen = 1'b0;
        run_ticks(5);
        pulse_side();
        chk("side_pending_set", int'(side_pending), 1);
        wait_phase(1, 200);
        wait_phase(3, 200);
        wait_phase(0, 400);
        cyc();
        cyc();
        chk("dur_mg", last_dur[0], 20);
        chk("dur_my", last_dur[1], 6);
        chk("dur_ar1", last_dur[2], 2);
        chk("dur_sg", last_dur[3], 15);
        chk("dur_sy", last_dur[4], 6);
        chk("dur_ar2", last_dur[5], 2);
        chk("side_walk_seen", int'(walk_seen), 0);

        // Pedestrian request after main green has expired: immediate exit, long walk
        run_ticks(30);
        ped_req = 1'b1;
        cyc();
        ped_req = 1'b0;
        cyc();
        chk("ped_immediate_exit", int'(phase), 1);
        wait_phase(3, 200);
        chk("ped_cleared_on_sg", int'(ped_pending), 0);
        chk("ped_walk_on", int'(walk), 1);
        wait_phase(4, 400);
        chk("ped_walk_off_sy", int'(walk), 0);
        wait_phase(0, 400);
        cyc();
        cyc();
        chk("ped_dur_sg", last_dur[3], 25);

        // Pedestrian request exactly on the AR1->SG edge
        pulse_side();
        wait_phase(2, 400);
        for (int i = 0; i < 100 && !(int'(phase) == 2 && m_rem == 0); i++) cyc();
        ped_req = 1'b1;
        cyc();
        ped_req = 1'b0;
        chk("edge_sg_entry", int'(phase), 3);
        chk("edge_walk", int'(walk), 1);
        chk("edge_ped_clear", int'(ped_pending), 0);
        cyc();
        chk("edge_ped_stays_clear", int'(ped_pending), 0);
        wait_phase(0, 400);
        cyc();
        cyc();
        chk("edge_dur_sg", last_dur[3], 25);

        // Config write mid-SG only affects the next SG
        pulse_side();
        wait_phase(3, 400);
        run_ticks(4);
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 8'd3;
        cyc();
        cfg_we = 1'b0;
        wait_phase(0, 400);
        cyc();
        cyc();
        chk("cfg_sg_unchanged", last_dur[3], 15);
        full_side_cycle("cfg_sg_3", 3);
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 8'd0;
        cyc();
        cfg_we = 1'b0;
        full_side_cycle("cfg_sg_0_is_1", 1);

        // Asynchronous reset mid-SY, then config back to defaults
        pulse_side();
        wait_phase(4, 400);
        cyc();
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_phase", int'(phase), 0);
        chk("async_rst_main", int'(main_lights), 1);
        chk("async_rst_side", int'(side_lights), 4);
        chk("async_rst_walk_pend", int'({walk, side_pending, ped_pending}), 0);
        do_reset();
        full_side_cycle("cfg_revert_sg", 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
